// File: rtl/ram_port_arbiter.sv
`timescale 1ns/1ps
// ram_port_arbiter
// Shares one synchronous-read RAM between the CPU control unit (port 0) and
// a DMA / program-loader master (port 1). Every access is a GNT cycle, with
// the strobe high, followed by a DONE cycle in which read data comes back.
// Under contention the grants alternate between the two ports. The CPU is
// held through cpu_stall until its access completes.
module ram_port_arbiter #(
  parameter int adlines   = 8,
  parameter int datalines = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  // CPU port
  input  logic                 cpu_read,
  input  logic                 cpu_write,
  input  logic [adlines-1:0]   cpu_addr,
  input  logic [datalines-1:0] cpu_wdata,
  output logic [datalines-1:0] cpu_rdata,
  output logic                 cpu_stall,
  // DMA / loader port
  input  logic                 dma_req,
  input  logic                 dma_we,
  input  logic [adlines-1:0]   dma_addr,
  input  logic [datalines-1:0] dma_wdata,
  output logic                 dma_ack,
  output logic [datalines-1:0] dma_rdata,
  // Physical RAM
  output logic [adlines-1:0]   ram_addr,
  output logic                 ram_read,
  output logic                 ram_write,
  output logic [datalines-1:0] ram_wdata,
  input  logic [datalines-1:0] ram_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    CPU_GNT,
    CPU_DONE,
    DMA_GNT,
    DMA_DONE
  } state_t;

  // Which port was served most recently. Round-robin hands a tie to the other port.
  localparam logic GRANT_CPU = 1'b0;
  localparam logic GRANT_DMA = 1'b1;

  state_t                 r_state;
  state_t                 w_next_state;
  logic                   r_last_grant;
  logic                   r_cpu_is_read;   // in-flight CPU access is a read
  logic                   r_dma_is_read;   // in-flight DMA access is a read
  logic [datalines-1:0]   r_cpu_rdata_hold;
  logic                   w_cpu_req;

  assign w_cpu_req = cpu_read | cpu_write;

  // Next-state selection. Requests are looked at only in IDLE and DONE states.
  always_comb begin
    // NOTE: default assigned first so every path drives w_next_state and no latch is inferred.
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_cpu_req && dma_req) begin
          w_next_state = (r_last_grant == GRANT_DMA) ? CPU_GNT : DMA_GNT;
        end else if (w_cpu_req) begin
          w_next_state = CPU_GNT;
        end else if (dma_req) begin
          w_next_state = DMA_GNT;
        end
      end
      CPU_GNT:  w_next_state = CPU_DONE;
      // The port just served is ignored here. Only the other port can chain in directly.
      CPU_DONE: w_next_state = dma_req ? DMA_GNT : IDLE;
      DMA_GNT:  w_next_state = DMA_DONE;
      DMA_DONE: w_next_state = w_cpu_req ? CPU_GNT : IDLE;
      default:  w_next_state = IDLE;
    endcase
  end

  // State register. A synchronous reset aborts any in-flight access.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Latch the winning port's address, data and strobe on entry to its GNT state.
  // Strobes default low, so they are high for exactly the one GNT cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ram_read      <= 1'b0;
      ram_write     <= 1'b0;
      ram_addr      <= '0;
      ram_wdata     <= '0;
      r_last_grant  <= GRANT_DMA;
      r_cpu_is_read <= 1'b0;
      r_dma_is_read <= 1'b0;
    end else begin
      ram_read  <= 1'b0;
      ram_write <= 1'b0;
      if (w_next_state == CPU_GNT) begin
        // A CPU request is known to be present here, so "not a write" means a read.
        // A write wins when both CPU strobes are high.
        ram_addr      <= cpu_addr;
        ram_wdata     <= cpu_wdata;
        ram_write     <= cpu_write;
        ram_read      <= ~cpu_write;
        r_cpu_is_read <= ~cpu_write;
        r_last_grant  <= GRANT_CPU;
      end else if (w_next_state == DMA_GNT) begin
        ram_addr      <= dma_addr;
        ram_wdata     <= dma_wdata;
        ram_write     <= dma_we;
        ram_read      <= ~dma_we;
        r_dma_is_read <= ~dma_we;
        r_last_grant  <= GRANT_DMA;
      end
    end
  end

  // Keep the last CPU read result so cpu_rdata stays stable after DONE.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cpu_rdata_hold <= '0;
    end else if (r_state == CPU_DONE && r_cpu_is_read) begin
      r_cpu_rdata_hold <= ram_rdata;
    end
  end

  // CPU-facing outputs. The stall drops in the DONE cycle so the CPU samples
  // the data at the edge that ends DONE.
  assign cpu_stall = w_cpu_req && (r_state != CPU_DONE);
  assign cpu_rdata = (r_state == CPU_DONE && r_cpu_is_read) ? ram_rdata : r_cpu_rdata_hold;

  // DMA-facing outputs. The ack pulses for the single DONE cycle.
  assign dma_ack   = (r_state == DMA_DONE);
  assign dma_rdata = (r_state == DMA_DONE && r_dma_is_read) ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
`timescale 1ns/1ps
// Directed testbench for ram_port_arbiter with a behavioural synchronous RAM.
// Inputs change 1ns after posedge. Outputs are sampled on the negedge.
module tb_ram_port_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic          cpu_read, cpu_write;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_stall;
  logic          dma_req, dma_we, dma_ack;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata, dma_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_read, ram_write;
  logic [DW-1:0] ram_wdata, ram_rdata;

  // Backdoor preload port into the RAM model.
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_data;

  logic [DW-1:0] mem [0:255];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.adlines(AW), .datalines(DW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cpu_read  (cpu_read),
    .cpu_write (cpu_write),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_ack   (dma_ack),
    .dma_rdata (dma_rdata),
    .ram_addr  (ram_addr),
    .ram_read  (ram_read),
    .ram_write (ram_write),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // Synchronous-read RAM: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (ram_write) mem[ram_addr] <= ram_wdata;
    if (ram_read) ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic backdoor(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    cyc();
    bd_we = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;

    // Preload while reset is held.
    backdoor(8'h05, 16'h1234);
    backdoor(8'h07, 16'h0777);
    backdoor(8'h20, 16'h5A5A);
    backdoor(8'h11, 16'h1111);
    smp();
    check("rst_ram_read",  ram_read,  1'b0);
    check("rst_ram_write", ram_write, 1'b0);
    check("rst_ram_addr",  ram_addr,  8'h00);
    check("rst_ram_wdata", ram_wdata, 16'h0000);
    check("rst_dma_ack",   dma_ack,   1'b0);
    check("rst_cpu_rdata", cpu_rdata, 16'h0000);
    check("rst_cpu_stall", cpu_stall, 1'b0);
    check("rst_dma_rdata", dma_rdata, 16'h0000);
    cyc(); rstn = 1'b1;

    // 1: uncontended CPU read of 0x05.
    cyc(); cpu_read = 1'b1; cpu_addr = 8'h05;
    smp();
    check("t1_c0_stall", cpu_stall, 1'b1);
    check("t1_c0_read",  ram_read,  1'b0);
    cyc(); smp();
    check("t1_c1_read",  ram_read,  1'b1);
    check("t1_c1_addr",  ram_addr,  8'h05);
    check("t1_c1_stall", cpu_stall, 1'b1);
    check("t1_c1_write", ram_write, 1'b0);
    cyc(); smp();
    check("t1_c2_stall", cpu_stall, 1'b0);
    check("t1_c2_rdata", cpu_rdata, 16'h1234);
    check("t1_c2_read",  ram_read,  1'b0);
    cyc(); cpu_read = 1'b0;
    smp();
    check("t1_c3_read",  ram_read,  1'b0);
    check("t1_c3_stall", cpu_stall, 1'b0);
    check("t1_c3_hold",  cpu_rdata, 16'h1234);

    // 2: DMA write of 0xBEEF to 0x10; address and data change during GNT.
    cyc(); dma_req = 1'b1; dma_we = 1'b1; dma_addr = 8'h10; dma_wdata = 16'hBEEF;
    smp();
    check("t2_c0_write", ram_write, 1'b0);
    check("t2_c0_ack",   dma_ack,   1'b0);
    cyc(); dma_addr = 8'h11; dma_wdata = 16'h0000;
    smp();
    check("t2_c1_write", ram_write, 1'b1);
    check("t2_c1_addr",  ram_addr,  8'h10);
    check("t2_c1_wdata", ram_wdata, 16'hBEEF);
    check("t2_c1_read",  ram_read,  1'b0);
    check("t2_c1_ack",   dma_ack,   1'b0);
    cyc(); smp();
    check("t2_c2_write", ram_write, 1'b0);
    check("t2_c2_ack",   dma_ack,   1'b1);
    check("t2_c2_rdata", dma_rdata, 16'h0000);
    cyc(); dma_req = 1'b0; dma_we = 1'b0;
    smp();
    check("t2_c3_ack",   dma_ack,   1'b0);
    check("t2_mem10",    mem[8'h10], 16'hBEEF);
    check("t2_mem11",    mem[8'h11], 16'h1111);

    // 3: simultaneous requests after reset -> CPU first, then DMA.
    cyc(); rstn = 1'b0;
    cyc(); rstn = 1'b1;
    cyc(); cpu_read = 1'b1; cpu_addr = 8'h07; dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'h20;
    smp();
    check("t3_c0_stall", cpu_stall, 1'b1);
    cyc(); smp();
    check("t3_c1_read",  ram_read,  1'b1);
    check("t3_c1_addr",  ram_addr,  8'h07);
    check("t3_c1_stall", cpu_stall, 1'b1);
    check("t3_c1_ack",   dma_ack,   1'b0);
    cyc(); smp();
    check("t3_c2_stall", cpu_stall, 1'b0);
    check("t3_c2_rdata", cpu_rdata, 16'h0777);
    cyc(); cpu_read = 1'b0;
    smp();
    check("t3_c3_read",  ram_read,  1'b1);
    check("t3_c3_addr",  ram_addr,  8'h20);
    check("t3_c3_stall", cpu_stall, 1'b0);
    check("t3_c3_ack",   dma_ack,   1'b0);
    cyc(); smp();
    check("t3_c4_ack",   dma_ack,   1'b1);
    check("t3_c4_drd",   dma_rdata, 16'h5A5A);
    check("t3_c4_read",  ram_read,  1'b0);
    cyc(); dma_req = 1'b0;
    smp();
    check("t3_c5_ack",   dma_ack,   1'b0);
    check("t3_c5_drd",   dma_rdata, 16'h0000);
    check("t3_c5_hold",  cpu_rdata, 16'h0777);

    // 4: continuous contention. Phases repeat CPU_GNT, CPU_DONE, DMA_GNT, DMA_DONE.
    cyc(); cpu_read = 1'b1; cpu_addr = 8'h05; dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'h20;
    smp();
    check("t4_c0_stall", cpu_stall, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      int ph;
      cyc(); smp();
      ph = (k - 1) % 4;
      check($sformatf("rr%0d_read", k),    ram_read,  (ph == 0 || ph == 2));
      check($sformatf("rr%0d_write", k),   ram_write, 1'b0);
      check($sformatf("rr%0d_ack", k),     dma_ack,   (ph == 3));
      check($sformatf("rr%0d_stall", k),   cpu_stall, (ph != 1));
      if (ph == 0) check($sformatf("rr%0d_addr", k), ram_addr, 8'h05);
      if (ph == 2) check($sformatf("rr%0d_addr", k), ram_addr, 8'h20);
      if (ph == 1) check($sformatf("rr%0d_crd", k),  cpu_rdata, 16'h1234);
      if (ph == 3) check($sformatf("rr%0d_drd", k),  dma_rdata, 16'h5A5A);
    end
    cyc(); cpu_read = 1'b0; dma_req = 1'b0;
    cyc();
    cyc(); smp();
    check("t4_end_read",  ram_read,  1'b0);
    check("t4_end_ack",   dma_ack,   1'b0);
    check("t4_end_stall", cpu_stall, 1'b0);

    // 5: reset during the GNT cycle of a CPU write.
    cyc(); cpu_write = 1'b1; cpu_addr = 8'h40; cpu_wdata = 16'h5555;
    smp();
    check("t5_c0_stall", cpu_stall, 1'b1);
    cyc(); smp();
    check("t5_c1_write", ram_write, 1'b1);
    check("t5_c1_addr",  ram_addr,  8'h40);
    rstn = 1'b0; cpu_write = 1'b0;
    cyc(); smp();
    check("t5_c2_write", ram_write, 1'b0);
    check("t5_c2_read",  ram_read,  1'b0);
    check("t5_c2_addr",  ram_addr,  8'h00);
    check("t5_c2_ack",   dma_ack,   1'b0);
    check("t5_c2_stall", cpu_stall, 1'b0);
    check("t5_c2_hold",  cpu_rdata, 16'h0000);
    cyc(); rstn = 1'b1;
    cyc(); cpu_read = 1'b1; cpu_addr = 8'h05;
    smp();
    check("t5_r0_stall", cpu_stall, 1'b1);
    cyc(); smp();
    check("t5_r1_read",  ram_read,  1'b1);
    check("t5_r1_addr",  ram_addr,  8'h05);
    cyc(); smp();
    check("t5_r2_stall", cpu_stall, 1'b0);
    check("t5_r2_rdata", cpu_rdata, 16'h1234);
    cyc(); cpu_read = 1'b0;

    // 6: write 0x00AA to 0x03 (write wins over the simultaneous read), then read it back.
    cyc(); cpu_write = 1'b1; cpu_read = 1'b1; cpu_addr = 8'h03; cpu_wdata = 16'h00AA;
    smp();
    check("t6_c0_stall", cpu_stall, 1'b1);
    cyc(); smp();
    check("t6_c1_write", ram_write, 1'b1);
    check("t6_c1_read",  ram_read,  1'b0);
    check("t6_c1_addr",  ram_addr,  8'h03);
    check("t6_c1_wdata", ram_wdata, 16'h00AA);
    cyc(); smp();
    check("t6_c2_stall", cpu_stall, 1'b0);
    check("t6_c2_write", ram_write, 1'b0);
    cyc(); cpu_write = 1'b0;
    smp();
    check("t6_c3_stall", cpu_stall, 1'b1);
    check("t6_c3_read",  ram_read,  1'b0);
    check("t6_mem03",    mem[8'h03], 16'h00AA);
    cyc(); smp();
    check("t6_c4_read",  ram_read,  1'b1);
    check("t6_c4_addr",  ram_addr,  8'h03);
    cyc(); smp();
    check("t6_c5_stall", cpu_stall, 1'b0);
    check("t6_c5_rdata", cpu_rdata, 16'h00AA);
    cyc(); cpu_read = 1'b0;
    smp();
    check("t6_c6_hold",  cpu_rdata, 16'h00AA);
    repeat (3) cyc();
    smp();
    check("t6_idle_hold",  cpu_rdata, 16'h00AA);
    check("t6_idle_stall", cpu_stall, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single synchronous-read RAM between two requesters: the CPU control unit (port 0) and a DMA/program-loader master (port 1).
- Drives the physical RAM address, data and strobes.
- Stalls the CPU through its enable input while a CPU access is pending or has lost arbitration.
- Sits between the control unit, the loader and the RAM at the top level.

Parameters:
adlines, 8, RAM address width
datalines, 16, RAM data width

Ports:
clk  in  1  system clock; all state updates on posedge
rstn  in  1  reset, synchronous, active-low
cpu_read  in  1  CPU read request (level)
cpu_write  in  1  CPU write request (level); wins over cpu_read if both high
cpu_addr  in  adlines  CPU address
cpu_wdata  in  datalines  CPU write data
cpu_rdata  out  datalines  read data to CPU
cpu_stall  out  1  high = hold CPU (drive its enable low)
dma_req  in  1  DMA request (level, held until ack)
dma_we  in  1  1 = write, 0 = read
dma_addr  in  adlines  DMA address
dma_wdata  in  datalines  DMA write data
dma_ack  out  1  one-cycle completion pulse
dma_rdata  out  datalines  DMA read data, valid while dma_ack=1
ram_addr  out  adlines  RAM address (registered)
ram_read  out  1  RAM read strobe (registered)
ram_write  out  1  RAM write strobe (registered)
ram_wdata  out  datalines  RAM write data (registered)
ram_rdata  in  datalines  RAM read data, valid the cycle after the read strobe

Behaviour:
- Reset (rstn=0 at posedge) sets the following:
  - state=IDLE.
  - ram_read=0, ram_write=0, ram_addr=0, ram_wdata=0.
  - dma_ack=0.
  - cpu_rdata hold register=0.
  - last_grant=DMA, so the CPU wins the first tie.
- Reset mid-transaction aborts it: strobes are low from the next cycle and no ack/stall release is produced for the aborted access.
- States: IDLE, CPU_GNT, CPU_DONE, DMA_GNT, DMA_DONE.
- IDLE:
  - CPU request = cpu_read|cpu_write.
  - Only one port requesting -> go to that port's GNT.
  - Both requesting -> go to the port opposite last_grant (round-robin).
  - Neither requesting -> stay in IDLE.
- On entry to X_GNT:
  - Register addr, wdata and the strobe from that port; only one strobe high.
  - Set last_grant=X.
  - Strobes are high for exactly the GNT cycle.
- X_GNT -> X_DONE unconditionally.
- X_DONE:
  - Strobes low.
  - If the other port is requesting, go directly to its GNT; otherwise go to IDLE.
  - The just-served port's request is ignored in DONE.
- CPU port:
  - cpu_stall = (cpu_read|cpu_write) && state!=CPU_DONE (combinational).
  - cpu_rdata = ram_rdata while in CPU_DONE after a read; otherwise the hold register, which is loaded at the end of each CPU read DONE.
  - Uncontended read: request seen in IDLE at cycle 0, strobe in cycle 1, data and stall=0 in cycle 2. The CPU samples at the posedge ending cycle 2.
  - A CPU request still high after completion is served again as a new transaction. This is harmless for repeated reads and idempotent for repeated writes of the same data.
- DMA port:
  - dma_ack=1 only in DMA_DONE.
  - dma_rdata = ram_rdata in DMA_DONE (read); 0 otherwise.
  - The master may drop or change the request in the cycle after ack.
- Fairness:
  - Under continuous contention, grants alternate CPU, DMA, CPU, ...
  - Each port waits at most one other transaction (2 cycles) before its GNT.
- Request inputs are sampled only in IDLE/DONE. Address/data changes during GNT/DONE do not affect the in-flight access.

Test Plan:
- Reset then cpu_read=1, cpu_addr=0x05 with RAM[5]=0x1234 -> ram_read=1/ram_addr=0x05 in cycle 1; cycle 2 cpu_stall=0, cpu_rdata=0x1234; cpu_stall=1 in cycles 0-1.
- dma_req=1, dma_we=1, dma_addr=0x10, dma_wdata=0xBEEF -> ram_write=1 for exactly one cycle with addr 0x10/data 0xBEEF; dma_ack pulses one cycle later; RAM[0x10]=0xBEEF.
- cpu_read and dma_req (read 0x20) rise in the same cycle after reset -> CPU granted first (cycles 1-2), DMA_GNT in cycle 3, dma_ack in cycle 4; cpu_stall stays 1 until cycle 2 only.
- Both ports held requesting for 12 cycles -> grant order CPU, DMA, CPU, DMA, CPU, DMA, with no idle cycles between transactions and no strobe overlap.
- rstn=0 during CPU_GNT of a write -> ram_write=0 from the next cycle, state=IDLE, dma_ack=0; CPU read after release completes normally with 2-cycle latency.
- CPU write to 0x03 (0x00AA) then read of 0x03 with cpu_read held -> cpu_rdata=0x00AA on the DONE cycle; the hold register keeps 0x00AA while idle.
